fp16_row_gather: RTL
====================

// Module: fp16_row_gather
// PURPOSE
//   Serial-to-parallel row assembler placed directly upstream of the 64-input FP16 max tree.
//   Collects one softmax row of FP16 scores from a LANES-wide AXI-stream.
//   Pads short rows with -inf and presents the row as one N_ELEM*16 vector with a valid/ready handshake.
//   Two row banks (ping-pong): the next row streams in while the current row waits for the max tree.
// PARAMETERS
//   N_ELEM     64        elements per row; equals the max tree's input count
//   LANES      4         FP16 elements per input beat; must divide N_ELEM
//   PAD_VALUE  16'hFC00  FP16 -inf; written to unused positions so they never win the max
// PORTS
//   clk            in   1              single clock, rising edge
//   rst            in   1              synchronous, active-high reset
//   s_tdata        in   LANES*16       lane k = element (beat_idx*LANES + k), lane 0 in LSBs
//   s_tvalid       in   1              input beat valid
//   s_tready       out  1              input beat accepted when s_tvalid & s_tready
//   s_tlast        in   1              last beat of the row
//   x              out  N_ELEM*16      assembled row, element i at x[i*16 +: 16]
//   x_valid        out  1              row available to the max tree
//   max_ready_all  in   1              max tree ready; row transfers when x_valid & max_ready_all
//   row_len        out  $clog2(N_ELEM)+1  elements actually received in the presented row (LANES..N_ELEM)
//   overflow_err   out  1              one-cycle pulse: row exceeded N_ELEM elements, surplus dropped
// BEHAVIOUR
//   Reset (rst=1 at edge):
//     - both banks empty; wr_sel = rd_sel = 0; write FSM = FILL, wr_idx = 0
//     - bank data = PAD_VALUE, bank length = 0
//     - outputs: s_tready=0 while rst high, x_valid=0, x = all PAD_VALUE, row_len=0, overflow_err=0
//     - a partial row in flight is discarded; no output pulse
//   Write FSM (states FILL, DROP):
//     - FILL: s_tready = !full[wr_sel]. An accepted beat writes LANES elements at wr_idx, then wr_idx += LANES.
//     - Row closes on an accepted beat with s_tlast=1 or with wr_idx == N_ELEM-LANES:
//       full[wr_sel] <= 1, len <= wr_idx+LANES, wr_sel toggles, wr_idx <= 0.
//     - Close at N_ELEM without s_tlast -> DROP, and overflow_err pulses in the next cycle.
//     - DROP: s_tready = 1; beats are accepted and discarded until the s_tlast beat, then return to FILL.
//       overflow_err pulses only once per row.
//   Read side:
//     - x_valid = full[rd_sel]; x and row_len come from bank rd_sel.
//     - Elements at index >= len read as PAD_VALUE (output mask, no prefill).
//     - While x_valid=1 and max_ready_all=0, x and row_len are held stable.
//     - Transfer: full[rd_sel] <= 0 and rd_sel toggles.
//   Latency: the closing beat is accepted at edge T; x_valid=1 from T+1 if that bank is next to read.
//     Peak throughput: one beat per cycle, with no bubble between rows while the other bank is free.
//   Simultaneous events:
//     - A row closing into bank A while bank B transfers in the same cycle: apply both updates.
//     - Bank A becomes readable right after B drains; no lost or duplicated row.
//   Backpressure: both banks full -> s_tready=0 (FILL) until a transfer frees the write bank.
//     s_tready then rises the cycle after the transfer.
//   Width rules: row_len is always a multiple of LANES. wr_idx is $clog2(N_ELEM) bits and never wraps
//     (rows close at N_ELEM-LANES).
//   No FP16 arithmetic: data passes bit-exact, including NaN/denormal payloads.
// STRUCTURE
//   Package fp16_softmax_pkg:
//     - typedef logic [15:0] fp16_t
//     - localparam FP16_W=16, FP16_NEG_INF=16'hFC00
//     - typedef enum {FILL, DROP} gather_state_e
//   Sub-module fp16_row_bank, instanced twice:
//     - N_ELEM fp16_t regs, LANES-wide indexed write, len register, full flag with set/clear
//     - masked read port
//   Top level holds the write FSM, wr_sel/rd_sel, the output mux and the overflow pulse.
// TESTING
//   1. Reset, then 16 beats (LANES=4) of elements i=0..63 (value 16'h3C00+i), tlast on beat 16, max_ready_all=1
//      -> x_valid at T+1, x[i]=3C00+i, row_len=64, one-cycle transfer, no overflow_err.
//   2. Short row: 3 beats, tlast on the 3rd
//      -> row_len=12, x[0..11] = data, x[12..63] = 16'hFC00.
//   3. max_ready_all=0; stream 3 full rows
//      -> rows 1 and 2 fill both banks, s_tready=0 on row 3's first beat, x stable.
//      Release ready -> rows delivered 1,2,3 in order, s_tready rises the cycle after each transfer.
//   4. Row of 18 beats with tlast on beat 18
//      -> row closes at 64 elements, overflow_err=1 for exactly one cycle, beats 17-18 accepted and dropped.
//      The next row is assembled correctly.
//   5. rst=1 mid-row (after 5 beats) and with one bank full
//      -> x_valid=0, row_len=0, x all FC00, overflow_err=0. A fresh row afterwards starts at element 0.
//   6. Closing beat of bank 1 in the same cycle bank 0 transfers
//      -> next cycle x_valid=1 with bank 1 data, with no gap and no duplicate transfer.

Source files
------------

// File: rtl/fp16_softmax_pkg.sv
// Shared types and constants for the FP16 softmax datapath.
package fp16_softmax_pkg;

    localparam int FP16_W = 16;

    typedef logic [FP16_W-1:0] fp16_t;

    // Negative infinity: the padding value that can never win a max reduction.
    localparam fp16_t FP16_NEG_INF = 16'hFC00;

    // Row-gather write side: FILL assembles a row, DROP discards an overlong row's tail.
    typedef enum logic {
        FILL = 1'b0,
        DROP = 1'b1
    } gather_state_e;

endpackage

// File: rtl/fp16_row_bank.sv
// One row buffer of the ping-pong pair: N_ELEM FP16 registers with a LANES-wide
// indexed write, a length register, a full flag, and a masked read port that
// replaces every element at or beyond the stored length with the pad value.
module fp16_row_bank
    import fp16_softmax_pkg::*;
#(
    parameter int    N_ELEM    = 64,
    parameter int    LANES     = 4,
    parameter fp16_t PAD_VALUE = FP16_NEG_INF,
    localparam int   IDX_W     = $clog2(N_ELEM),
    localparam int   LEN_W     = $clog2(N_ELEM) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [LANES*FP16_W-1:0]    wr_data,
    input  logic                       set_full,
    input  logic [LEN_W-1:0]           set_len,
    input  logic                       clr_full,
    output logic                       full,
    output logic [LEN_W-1:0]           len,
    output logic [N_ELEM*FP16_W-1:0]   rd_data
);

    fp16_t data [N_ELEM];

    // Element storage: a write lands LANES consecutive elements starting at wr_idx.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ELEM; i++) begin
                data[i] <= PAD_VALUE;
            end
        end else if (wr_en) begin
            for (int k = 0; k < LANES; k++) begin
                data[wr_idx + IDX_W'(k)] <= wr_data[k*FP16_W +: FP16_W];
            end
        end
    end

    // Occupancy: set on row close (with its length), cleared when the row is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            len  <= '0;
        end else if (set_full) begin
            full <= 1'b1;
            len  <= set_len;
        end else if (clr_full) begin
            full <= 1'b0;
        end
    end

    // Masked read: stale data beyond the current row length is never exposed.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            rd_data[i*FP16_W +: FP16_W] = (LEN_W'(i) < len) ? data[i] : PAD_VALUE;
        end
    end

endmodule

// File: rtl/fp16_row_gather.sv
// Serial-to-parallel row assembler feeding the FP16 max tree. Beats of LANES
// elements are collected into one of two row banks; the other bank presents
// its completed row to the max tree. Short rows are padded with -inf via the
// bank read mask; rows longer than N_ELEM are truncated and flagged.
module fp16_row_gather
    import fp16_softmax_pkg::*;
#(
    parameter int    N_ELEM    = 64,
    parameter int    LANES     = 4,
    parameter fp16_t PAD_VALUE = FP16_NEG_INF,
    localparam int   IDX_W     = $clog2(N_ELEM),
    localparam int   LEN_W     = $clog2(N_ELEM) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LANES*FP16_W-1:0]    s_tdata,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic                       s_tlast,
    output logic [N_ELEM*FP16_W-1:0]   x,
    output logic                       x_valid,
    input  logic                       max_ready_all,
    output logic [LEN_W-1:0]           row_len,
    output logic                       overflow_err
);

    gather_state_e        state;
    logic [IDX_W-1:0]     wr_idx;
    logic                 wr_sel;
    logic                 rd_sel;

    logic [1:0]                  bank_full;
    logic [LEN_W-1:0]            bank_len  [2];
    logic [N_ELEM*FP16_W-1:0]    bank_data [2];

    logic                 fill_accept;
    logic                 last_slot;
    logic                 row_close;
    logic                 xfer;
    logic [LEN_W-1:0]     close_len;

    // Input handshake: FILL waits for a free write bank, DROP swallows everything.
    always_comb begin
        if (rst) begin
            s_tready = 1'b0;
        end else if (state == DROP) begin
            s_tready = 1'b1;
        end else begin
            s_tready = ~bank_full[wr_sel];
        end
    end

    // A row closes on tlast or when its final slot is written; rows never wrap wr_idx.
    always_comb begin
        fill_accept = (state == FILL) && s_tvalid && s_tready;
        last_slot   = (wr_idx == IDX_W'(N_ELEM - LANES));
        row_close   = fill_accept && (s_tlast || last_slot);
        close_len   = {1'b0, wr_idx} + LEN_W'(LANES);
        xfer        = x_valid && max_ready_all;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fp16_row_bank #(
            .N_ELEM    (N_ELEM),
            .LANES     (LANES),
            .PAD_VALUE (PAD_VALUE)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (fill_accept && (wr_sel == 1'(b))),
            .wr_idx   (wr_idx),
            .wr_data  (s_tdata),
            .set_full (row_close && (wr_sel == 1'(b))),
            .set_len  (close_len),
            .clr_full (xfer && (rd_sel == 1'(b))),
            .full     (bank_full[b]),
            .len      (bank_len[b]),
            .rd_data  (bank_data[b])
        );
    end

    // Read side: the bank selected by rd_sel is what the max tree sees.
    always_comb begin
        x_valid = bank_full[rd_sel];
        x       = bank_data[rd_sel];
        row_len = bank_len[rd_sel];
    end

    // Write FSM, bank pointers and the one-shot overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FILL;
            wr_idx       <= '0;
            wr_sel       <= 1'b0;
            rd_sel       <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            overflow_err <= 1'b0;
            if (xfer) begin
                rd_sel <= ~rd_sel;
            end
            case (state)
                FILL: begin
                    if (fill_accept) begin
                        if (row_close) begin
                            wr_idx <= '0;
                            wr_sel <= ~wr_sel;
                            if (last_slot && !s_tlast) begin
                                state        <= DROP;
                                overflow_err <= 1'b1;
                            end
                        end else begin
                            wr_idx <= wr_idx + IDX_W'(LANES);
                        end
                    end
                end
                DROP: begin
                    if (s_tvalid && s_tlast) begin
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
